// File: rtl/mips_mem_responder_pkg.sv
// Shared definitions for the MIPS data-memory responder: state encoding, strobe width
// and the sizing rule for the latency down-counter.
package mips_mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int STRB_W = 4;

  // The counter is loaded with LATENCY-1, so it must hold values up to LATENCY-1.
  function automatic int cnt_width(input int latency);
    return (latency <= 2) ? 1 : $clog2(latency);
  endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// CPU data-port bus between mips_cpu (master) and the memory responder (slave).
interface mips_mem_responder_if;
  import mips_mem_pkg::*;

  logic [31:0]       Address;
  logic              MemRead;
  logic              MemWrite;
  logic [31:0]       Write_data;
  logic [STRB_W-1:0] Write_strb;
  logic              Mem_Req_Ready;
  logic [31:0]       Read_data;
  logic              Read_data_Valid;
  logic              Read_data_Ready;

  modport master (
    output Address, MemRead, MemWrite, Write_data, Write_strb, Read_data_Ready,
    input  Mem_Req_Ready, Read_data, Read_data_Valid
  );

  modport slave (
    input  Address, MemRead, MemWrite, Write_data, Write_strb, Read_data_Ready,
    output Mem_Req_Ready, Read_data, Read_data_Valid
  );

endinterface

// File: rtl/mips_mem_responder_array.sv
// Single-port word RAM, synchronous read and byte-strobed write. No reset: contents and
// the read register survive resetn.
module mips_mem_array
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-3:0] idx,
  input  logic [31:0]           wdata,
  input  logic [STRB_W-1:0]     strb,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // A write never disturbs the read register, so the last response stays on Read_data.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < STRB_W; i++) begin
          if (strb[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mips_mem_responder.sv
// Handshaked fixed-latency data memory for mips_cpu: one access at a time, byte-strobed
// writes, read/write perf counters.
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  mips_mem_responder_if.slave  bus,
  output logic [31:0]          rd_cnt,
  output logic [31:0]          wr_cnt
);

  // state   | meaning
  // IDLE    | ready for a request
  // WAIT    | latency countdown; array access when the count reaches zero
  // RESP    | read response held until Read_data_Ready

  localparam int CW = cnt_width(LATENCY);
  localparam int IW = ADDR_WIDTH - 2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              is_wr_q, is_wr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic              valid_q, valid_d;
  logic              loaded_q, loaded_d;
  logic [31:0]       rd_cnt_q, rd_cnt_d;
  logic [31:0]       wr_cnt_q, wr_cnt_d;

  logic              arr_en;
  logic              arr_we;
  logic [31:0]       arr_rdata;
  logic              addr_unused;

  assign addr_unused = ^{bus.Address[31:ADDR_WIDTH], bus.Address[1:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    is_wr_d  = is_wr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    valid_d  = valid_q;
    loaded_d = loaded_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    arr_en   = 1'b0;
    arr_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.MemRead || bus.MemWrite) begin
          idx_d   = bus.Address[ADDR_WIDTH-1:2];
          is_wr_d = bus.MemWrite;
          wdata_d = bus.Write_data;
          strb_d  = bus.Write_strb;
          cnt_d   = CW'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          arr_en = 1'b1;
          arr_we = is_wr_q;
          if (is_wr_q) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
            state_d  = ST_IDLE;
          end else begin
            valid_d  = 1'b1;
            loaded_d = 1'b1;
            state_d  = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (valid_q && bus.Read_data_Ready) begin
          valid_d  = 1'b0;
          rd_cnt_d = rd_cnt_q + 32'd1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      is_wr_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      valid_q  <= 1'b0;
      loaded_q <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      is_wr_q  <= is_wr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      valid_q  <= valid_d;
      loaded_q <= loaded_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  mips_mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .strb  (strb_q),
    .rdata (arr_rdata)
  );

  // The RAM read register has no reset; mask it until a read has completed since reset.
  assign bus.Read_data       = loaded_q ? arr_rdata : 32'd0;
  assign bus.Read_data_Valid = valid_q;
  assign bus.Mem_Req_Ready   = (state_q == ST_IDLE);
  assign rd_cnt              = rd_cnt_q;
  assign wr_cnt              = wr_cnt_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: LATENCY=2 instance for most scenarios, a LATENCY=1
// instance for the single-cycle and aliasing case.
module tb_mips_mem_responder;

  logic        clk;
  logic        resetn;
  logic [31:0] rd_cnt2, wr_cnt2, rd_cnt1, wr_cnt1;
  int          compared;
  int          mismatched;
  int unsigned exp_wr;
  int unsigned exp_rd;

  mips_mem_responder_if bus2 ();
  mips_mem_responder_if bus1 ();

  mips_mem_responder #(.ADDR_WIDTH(11), .LATENCY(2)) dut2 (
    .clk(clk), .resetn(resetn), .bus(bus2), .rd_cnt(rd_cnt2), .wr_cnt(wr_cnt2)
  );

  mips_mem_responder #(.ADDR_WIDTH(11), .LATENCY(1)) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1), .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready2(input string name);
    int n = 0;
    while (!bus2.Mem_Req_Ready && n < 40) begin tick(); n++; end
    if (n >= 40) begin
      compared++; mismatched++;
      $display("FAIL %s: Mem_Req_Ready never rose within 40 cycles", name);
    end
  endtask

  task automatic wr2(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wait_ready2("wr2_accept");
    bus2.Address = a; bus2.Write_data = d; bus2.Write_strb = s; bus2.MemWrite = 1'b1;
    tick();
    bus2.MemWrite = 1'b0;
    wait_ready2("wr2_done");
    exp_wr++;
  endtask

  task automatic rd2(input logic [31:0] a, output logic [31:0] d);
    int n = 0;
    wait_ready2("rd2_accept");
    bus2.Address = a; bus2.MemRead = 1'b1;
    tick();
    bus2.MemRead = 1'b0;
    while (!bus2.Read_data_Valid && n < 40) begin tick(); n++; end
    if (n >= 40) begin
      compared++; mismatched++;
      $display("FAIL rd2_valid: Read_data_Valid never rose within 40 cycles");
    end
    d = bus2.Read_data;
    bus2.Read_data_Ready = 1'b1;
    tick();
    bus2.Read_data_Ready = 1'b0;
    exp_rd++;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    compared++; if (bus2.Mem_Req_Ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", bus2.Mem_Req_Ready); end
    compared++; if (bus2.Read_data_Valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", bus2.Read_data_Valid); end
    compared++; if (bus2.Read_data !== 32'd0) begin mismatched++; $display("FAIL reset_data: got %h want 0", bus2.Read_data); end
    compared++; if (rd_cnt2 !== 32'd0 || wr_cnt2 !== 32'd0) begin mismatched++; $display("FAIL reset_cnt: got rd=%0d wr=%0d want 0/0", rd_cnt2, wr_cnt2); end
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_read_latency();
    wr2(32'h40, 32'hCAFE_F00D, 4'hF);
    wr2(32'h10, 32'h0000_0000, 4'hF);
    wr2(32'h20, 32'h1122_3344, 4'hF);
    wr2(32'h08, 32'h0000_0000, 4'hF);
    wait_ready2("lat_idle");
    bus2.Address = 32'h40; bus2.MemRead = 1'b1;
    tick();
    bus2.MemRead = 1'b0;
    compared++; if (bus2.Mem_Req_Ready !== 1'b0 || bus2.Read_data_Valid !== 1'b0) begin mismatched++; $display("FAIL lat_edge1: ready=%b valid=%b want 0/0", bus2.Mem_Req_Ready, bus2.Read_data_Valid); end
    tick();
    compared++; if (bus2.Mem_Req_Ready !== 1'b0 || bus2.Read_data_Valid !== 1'b0) begin mismatched++; $display("FAIL lat_edge2: ready=%b valid=%b want 0/0", bus2.Mem_Req_Ready, bus2.Read_data_Valid); end
    tick();
    compared++; if (bus2.Read_data_Valid !== 1'b1) begin mismatched++; $display("FAIL lat_valid: got %b want 1", bus2.Read_data_Valid); end
    compared++; if (bus2.Read_data !== 32'hCAFE_F00D) begin mismatched++; $display("FAIL lat_data: got %h want cafef00d", bus2.Read_data); end
    bus2.Read_data_Ready = 1'b1;
    tick();
    bus2.Read_data_Ready = 1'b0;
    exp_rd++;
    compared++; if (bus2.Read_data_Valid !== 1'b0 || bus2.Mem_Req_Ready !== 1'b1) begin mismatched++; $display("FAIL lat_handshake: valid=%b ready=%b want 0/1", bus2.Read_data_Valid, bus2.Mem_Req_Ready); end
    compared++; if (rd_cnt2 !== 32'd1) begin mismatched++; $display("FAIL lat_rd_cnt: got %0d want 1", rd_cnt2); end
    compared++; if (bus2.Read_data !== 32'hCAFE_F00D) begin mismatched++; $display("FAIL lat_data_hold: got %h want cafef00d", bus2.Read_data); end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    wr2(32'h10, 32'hDEAD_BEEF, 4'b0101);
    rd2(32'h10, d);
    compared++; if (d !== 32'h00AD_00EF) begin mismatched++; $display("FAIL strobe_data: got %h want 00ad00ef", d); end
    compared++; if (wr_cnt2 !== 32'(exp_wr)) begin mismatched++; $display("FAIL strobe_wr_cnt: got %0d want %0d", wr_cnt2, exp_wr); end
    wr2(32'h10, 32'hFFFF_FFFF, 4'b0000);
    rd2(32'h10, d);
    compared++; if (d !== 32'h00AD_00EF) begin mismatched++; $display("FAIL strobe_zero: got %h want 00ad00ef", d); end
    compared++; if (wr_cnt2 !== 32'(exp_wr)) begin mismatched++; $display("FAIL strobe_zero_cnt: got %0d want %0d", wr_cnt2, exp_wr); end
  endtask

  task automatic test_resp_stall();
    int n = 0;
    wait_ready2("stall_idle");
    bus2.Address = 32'h40; bus2.MemRead = 1'b1;
    tick();
    bus2.Address = 32'h10;
    while (!bus2.Read_data_Valid && n < 40) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (bus2.Read_data_Valid !== 1'b1 || bus2.Read_data !== 32'hCAFE_F00D || bus2.Mem_Req_Ready !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_cycle%0d: valid=%b data=%h ready=%b want 1/cafef00d/0", i, bus2.Read_data_Valid, bus2.Read_data, bus2.Mem_Req_Ready);
      end
      tick();
    end
    bus2.MemRead = 1'b0;
    bus2.Read_data_Ready = 1'b1;
    tick();
    bus2.Read_data_Ready = 1'b0;
    exp_rd++;
    tick();
    compared++; if (rd_cnt2 !== 32'(exp_rd) || bus2.Mem_Req_Ready !== 1'b1) begin mismatched++; $display("FAIL stall_after: rd_cnt=%0d ready=%b want %0d/1", rd_cnt2, bus2.Mem_Req_Ready, exp_rd); end
  endtask

  task automatic test_rw_both();
    logic [31:0] d;
    logic        saw_valid = 1'b0;
    wait_ready2("both_idle");
    bus2.Address = 32'h8; bus2.Write_data = 32'h1234_5678; bus2.Write_strb = 4'hF;
    bus2.MemRead = 1'b1; bus2.MemWrite = 1'b1;
    tick();
    bus2.MemRead = 1'b0; bus2.MemWrite = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus2.Read_data_Valid) saw_valid = 1'b1;
      tick();
    end
    exp_wr++;
    compared++; if (saw_valid !== 1'b0) begin mismatched++; $display("FAIL both_valid: got %b want 0", saw_valid); end
    compared++; if (wr_cnt2 !== 32'(exp_wr) || rd_cnt2 !== 32'(exp_rd)) begin mismatched++; $display("FAIL both_cnt: rd=%0d wr=%0d want %0d/%0d", rd_cnt2, wr_cnt2, exp_rd, exp_wr); end
    rd2(32'h8, d);
    compared++; if (d !== 32'h1234_5678) begin mismatched++; $display("FAIL both_data: got %h want 12345678", d); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] d;
    wait_ready2("rst_idle");
    bus2.Address = 32'h20; bus2.Write_data = 32'hFFFF_FFFF; bus2.Write_strb = 4'hF; bus2.MemWrite = 1'b1;
    tick();
    bus2.MemWrite = 1'b0;
    #1 resetn = 1'b0;
    #1;
    compared++; if (bus2.Mem_Req_Ready !== 1'b1 || bus2.Read_data_Valid !== 1'b0 || bus2.Read_data !== 32'd0) begin mismatched++; $display("FAIL rst_outputs: ready=%b valid=%b data=%h want 1/0/0", bus2.Mem_Req_Ready, bus2.Read_data_Valid, bus2.Read_data); end
    compared++; if (rd_cnt2 !== 32'd0 || wr_cnt2 !== 32'd0) begin mismatched++; $display("FAIL rst_cnt: rd=%0d wr=%0d want 0/0", rd_cnt2, wr_cnt2); end
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    exp_rd = 0; exp_wr = 0;
    tick(); tick();
    rd2(32'h20, d);
    compared++; if (d !== 32'h1122_3344) begin mismatched++; $display("FAIL rst_nocommit: got %h want 11223344", d); end
  endtask

  task automatic test_alias_lat1();
    bus1.Address = 32'h800; bus1.Write_data = 32'hA5A5_0001; bus1.Write_strb = 4'hF; bus1.MemWrite = 1'b1;
    tick();
    bus1.MemWrite = 1'b0;
    tick();
    compared++; if (bus1.Mem_Req_Ready !== 1'b1 || wr_cnt1 !== 32'd1) begin mismatched++; $display("FAIL alias_wr: ready=%b wr_cnt=%0d want 1/1", bus1.Mem_Req_Ready, wr_cnt1); end
    bus1.Address = 32'h000; bus1.MemRead = 1'b1;
    tick();
    bus1.MemRead = 1'b0;
    compared++; if (bus1.Read_data_Valid !== 1'b0 || bus1.Mem_Req_Ready !== 1'b0) begin mismatched++; $display("FAIL lat1_accept: valid=%b ready=%b want 0/0", bus1.Read_data_Valid, bus1.Mem_Req_Ready); end
    tick();
    compared++; if (bus1.Read_data_Valid !== 1'b1) begin mismatched++; $display("FAIL lat1_valid: got %b want 1", bus1.Read_data_Valid); end
    compared++; if (bus1.Read_data !== 32'hA5A5_0001) begin mismatched++; $display("FAIL alias_data: got %h want a5a50001", bus1.Read_data); end
    bus1.Read_data_Ready = 1'b1;
    tick();
    bus1.Read_data_Ready = 1'b0;
    compared++; if (rd_cnt1 !== 32'd1 || bus1.Read_data_Valid !== 1'b0) begin mismatched++; $display("FAIL lat1_hs: rd_cnt=%0d valid=%b want 1/0", rd_cnt1, bus1.Read_data_Valid); end
  endtask

  initial begin
    compared = 0; mismatched = 0; exp_wr = 0; exp_rd = 0;
    bus2.Address = '0; bus2.MemRead = 0; bus2.MemWrite = 0; bus2.Write_data = '0;
    bus2.Write_strb = '0; bus2.Read_data_Ready = 0;
    bus1.Address = '0; bus1.MemRead = 0; bus1.MemWrite = 0; bus1.Write_data = '0;
    bus1.Write_strb = '0; bus1.Read_data_Ready = 0;
    test_reset();
    test_read_latency();
    test_strobe();
    test_resp_stall();
    test_rw_both();
    test_reset_mid_wait();
    test_alias_lat1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
